vga_dbg_snapshot: RTL and testbench

//  Tear-free debug-data source for the VGA debug console. Once per frame it scans the CPU

---
 rtl/vga_dbg_snapshot.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_dbg_snapshot.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dbg_snapshot.sv
// Tear-free debug snapshot for the VGA debug console.
// - Once per frame the debug address space is scanned into a back bank.
// - The front and back banks swap when the scan ends.
// - ROM/RAM bus writes are snooped into a mirror.
// - The renderer reads either the front bank or the mirror through one registered port.
module vga_dbg_snapshot #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DBG_LAT    = 1,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned MEM_IDX_LO = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync_start,
  input  logic              i_freeze,
  output logic [ADDR_W-1:0] o_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_data,
  input  logic              i_mem_wr_valid,
  input  logic [31:0]       i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_rd_sel,
  input  logic [MEM_AW-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [15:0]       o_frame_cnt
);

  localparam int unsigned N        = 1 << ADDR_W;
  localparam int unsigned MIR_D    = 1 << MEM_AW;
  localparam int unsigned PIPE     = (DBG_LAT == 0) ? 1 : DBG_LAT;
  localparam int unsigned LAT_LAST = (DBG_LAT == 0) ? 0 : DBG_LAT - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_dbg_addr;
  logic [ADDR_W-1:0]   w_dbg_addr_nxt;
  logic [1:0]          r_drain_cnt;
  logic [1:0]          w_drain_cnt_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_overrun;
  logic [15:0]         r_frame_cnt;
  logic                r_front;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_start;
  logic                w_last_addr;
  logic                w_drain_done;
  logic                w_scan_end;
  logic                w_swap;

  // Capture pipeline: delays (valid, addr) by DBG_LAT to line up with dbg_data
  logic [PIPE-1:0]     r_cap_v;
  logic [ADDR_W-1:0]   r_cap_a [PIPE];
  logic                w_cap_v;
  logic [ADDR_W-1:0]   w_cap_a;
  logic [ADDR_W:0]     w_cap_idx;

  // Storage: two debug banks packed as {bank, addr}; mirror indexed by word address
  logic [DATA_W-1:0]   r_bank   [2*N];
  logic [DATA_W-1:0]   r_mirror [MIR_D];
  logic [MEM_AW-1:0]   w_mem_idx;
  logic                w_unused_addr;

  assign w_start      = (r_state == S_IDLE) && i_vsync_start && !i_freeze;
  assign w_last_addr  = (r_dbg_addr == LAST_ADDR);
  assign w_drain_done = (r_state == S_DRAIN) && (r_drain_cnt == 2'(LAT_LAST));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DRAIN is bypassed when the debug path has no latency
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_last_addr) begin
          w_state_nxt = (DBG_LAT == 0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath decode: address walk, drain count, scan-end detection
  always_comb begin
    w_dbg_addr_nxt  = r_dbg_addr;
    w_drain_cnt_nxt = r_drain_cnt;
    w_scan_end      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dbg_addr_nxt  = '0;
        w_drain_cnt_nxt = '0;
      end
      S_SCAN: begin
        w_drain_cnt_nxt = '0;
        if (w_last_addr) begin
          w_scan_end = (DBG_LAT == 0);
        end else begin
          w_dbg_addr_nxt = r_dbg_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        w_drain_cnt_nxt = r_drain_cnt + 2'd1;
        w_scan_end      = w_drain_done;
      end
      default: begin
        w_dbg_addr_nxt  = '0;
        w_drain_cnt_nxt = '0;
      end
    endcase
    w_swap     = w_scan_end && !i_freeze;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Registered control outputs, bank select and frame counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dbg_addr  <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
      r_front     <= 1'b0;
    end else begin
      r_dbg_addr  <= w_dbg_addr_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_busy      <= w_busy_nxt;
      if (i_vsync_start && r_busy) begin
        r_overrun <= 1'b1;
      end
      if (w_swap) begin
        r_front     <= ~r_front;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Capture valid pipeline; cleared by reset so no stale capture follows it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_v <= '0;
    end else begin
      r_cap_v[0] <= (r_state == S_SCAN);
      for (int i = 1; i < int'(PIPE); i++) begin
        r_cap_v[i] <= r_cap_v[i-1];
      end
    end
  end

  // Capture address pipeline
  always_ff @(posedge i_clk) begin
    r_cap_a[0] <= r_dbg_addr;
    for (int i = 1; i < int'(PIPE); i++) begin
      r_cap_a[i] <= r_cap_a[i-1];
    end
  end

  assign w_cap_v   = (DBG_LAT == 0) ? (r_state == S_SCAN) : r_cap_v[PIPE-1];
  assign w_cap_a   = (DBG_LAT == 0) ? r_dbg_addr : r_cap_a[PIPE-1];
  assign w_cap_idx = {~r_front, w_cap_a};

  // Back-bank capture. The final capture shares its edge with the swap,
  // so it still lands in the pre-toggle back bank.
  always_ff @(posedge i_clk) begin
    if (w_cap_v && !i_rst) begin
      r_bank[w_cap_idx] <= i_dbg_data;
    end
  end

  assign w_mem_idx     = i_mem_addr[MEM_IDX_LO +: MEM_AW];
  assign w_unused_addr = ^{i_mem_addr[31:MEM_IDX_LO+MEM_AW], i_mem_addr[MEM_IDX_LO-1:0]};

  // Memory mirror snoop; upper address bits alias
  always_ff @(posedge i_clk) begin
    if (i_mem_wr_valid) begin
      r_mirror[w_mem_idx] <= i_mem_data;
    end
  end

  // Renderer read port. Reads are read-first against mirror writes
  // and against the bank toggle on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_sel) begin
      r_rd_data <= r_mirror[i_rd_addr];
    end else begin
      r_rd_data <= r_bank[{r_front, i_rd_addr[ADDR_W-1:0]}];
    end
  end

  assign o_dbg_addr  = r_dbg_addr;
  assign o_rd_data   = r_rd_data;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_dbg_snapshot.sv
// Directed bench for vga_dbg_snapshot.
// Read results go through a scoreboard queue; the other outputs are checked in place.
module tb_vga_dbg_snapshot;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_start;
  logic        freeze;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        mem_wr_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        rd_sel;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_cnt;

  logic [31:0] base = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  vga_dbg_snapshot dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_vsync_start  (vsync_start),
    .i_freeze       (freeze),
    .o_dbg_addr     (dbg_addr),
    .i_dbg_data     (dbg_data),
    .i_mem_wr_valid (mem_wr_valid),
    .i_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .i_rd_sel       (rd_sel),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_busy         (busy),
    .o_overrun      (overrun),
    .o_frame_cnt    (frame_cnt)
  );

  // Cycle counter and a one-cycle-latency debug datapath model
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dbg_data <= base | 32'(dbg_addr);

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_vsync();
    t0 = cyc;
    vsync_start = 1'b1;
    @(negedge clk);
    vsync_start = 1'b0;
  endtask

  // Busy must fall exactly N + DBG_LAT + 1 = 130 cycles after the pulse
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(cyc - t0), 32'd130);
  endtask

  task automatic rd_issue(input logic sel, input logic [7:0] a, input logic [31:0] exp,
                          input string tag);
    rd_sel  = sel;
    rd_addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic rd_check();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_underflow: observed empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, rd_data, e);
    end
  endtask

  task automatic rd(input logic sel, input logic [7:0] a, input logic [31:0] exp,
                    input string tag);
    rd_issue(sel, a, exp, tag);
    @(negedge clk);
    rd_check();
  endtask

  initial begin
    rst = 1'b1; vsync_start = 1'b0; freeze = 1'b0; mem_wr_valid = 1'b0;
    mem_addr = '0; mem_data = '0; rd_sel = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_dbg_addr", dbg_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    step();

    // 1: first scan fills bank 1 and swaps it to the front
    base = 32'hA000_0000;
    step();
    pulse_vsync();
    chk("t1_busy_start", busy, 1);
    chk("t1_addr0", dbg_addr, 0);
    step_to(t0 + 128);
    chk("t1_addr_last", dbg_addr, 127);
    step();
    chk("t1_drain_addr", dbg_addr, 127);
    chk("t1_drain_busy", busy, 1);
    wait_idle("t1_busy_len");
    chk("t1_frame_cnt", frame_cnt, 1);
    rd(1'b0, 8'd5, 32'hA000_0005, "t1_rd5");
    rd(1'b0, 8'd127, 32'hA000_007F, "t1_rd127");
    rd(1'b0, 8'd0, 32'hA000_0000, "t1_rd0");

    // 2: second scan is invisible until the swap; toggle-edge read is pre-toggle
    base = 32'hB000_0000;
    step();
    pulse_vsync();
    step_to(t0 + 51);
    chk("t2_addr50", dbg_addr, 50);
    rd(1'b0, 8'd5, 32'hA000_0005, "t2_mid_scan");
    step_to(t0 + 129);
    rd_issue(1'b0, 8'd5, 32'hA000_0005, "t2_toggle_read");
    step();
    rd_check();
    chk("t2_busy_fall", busy, 0);
    chk("t2_frame_cnt", frame_cnt, 2);
    rd(1'b0, 8'd5, 32'hB000_0005, "t2_new_rd5");
    rd(1'b0, 8'h85, 32'hB000_0005, "t2_rd_addr_hi");

    // 3: freeze blocks a start; freeze at scan end suppresses the swap
    base = 32'hC000_0000;
    freeze = 1'b1;
    step();
    pulse_vsync();
    chk("t3_frozen_idle", busy, 0);
    step();
    chk("t3_frozen_idle2", busy, 0);
    chk("t3_frozen_cnt", frame_cnt, 2);
    freeze = 1'b0;
    step();
    pulse_vsync();
    step_to(t0 + 60);
    freeze = 1'b1;
    wait_idle("t3_busy_len");
    chk("t3_frame_cnt", frame_cnt, 2);
    rd(1'b0, 8'd5, 32'hB000_0005, "t3_front_kept");
    freeze = 1'b0;

    // 4: vsync during a scan flags overrun without restarting
    base = 32'hD000_0000;
    step();
    pulse_vsync();
    step_to(t0 + 50);
    vsync_start = 1'b1;
    step();
    vsync_start = 1'b0;
    chk("t4_overrun", overrun, 1);
    chk("t4_no_restart", dbg_addr, 50);
    wait_idle("t4_busy_len");
    chk("t4_frame_cnt", frame_cnt, 3);
    chk("t4_overrun_sticky", overrun, 1);
    rd(1'b0, 8'd5, 32'hD000_0005, "t4_rd5");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_overrun_clr", overrun, 0);
    chk("t4_frame_clr", frame_cnt, 0);
    rd(1'b0, 8'd5, 32'hB000_0005, "t4_front_bank0");

    // 5: memory mirror, aliasing and read-first collision
    mem_wr_valid = 1'b1; mem_addr = 32'h0000_0010; mem_data = 32'h1234_5678;
    step();
    mem_wr_valid = 1'b0;
    rd(1'b1, 8'd4, 32'h1234_5678, "t5_mirror4");
    mem_wr_valid = 1'b1; mem_addr = 32'h0000_0410; mem_data = 32'hDEAD_BEEF;
    step();
    mem_wr_valid = 1'b0;
    rd(1'b1, 8'd4, 32'hDEAD_BEEF, "t5_alias4");
    mem_wr_valid = 1'b1; mem_addr = 32'h0000_0010; mem_data = 32'hCAFE_F00D;
    rd_issue(1'b1, 8'd4, 32'hDEAD_BEEF, "t5_collision_old");
    step();
    mem_wr_valid = 1'b0;
    rd_check();
    rd(1'b1, 8'd4, 32'hCAFE_F00D, "t5_after_collision");
    mem_wr_valid = 1'b1; mem_addr = 32'hFFFF_FFFC; mem_data = 32'h0000_FFFF;
    step();
    mem_wr_valid = 1'b0;
    rd(1'b1, 8'd255, 32'h0000_FFFF, "t5_top_index");
    rd(1'b0, 8'd5, 32'hB000_0005, "t5_dbg_untouched");

    // 6: reset mid-scan keeps the current front snapshot
    base = 32'hE000_0000;
    step();
    pulse_vsync();
    step_to(t0 + 60);
    rst = 1'b1;
    step();
    chk("t6_busy", busy, 0);
    chk("t6_dbg_addr", dbg_addr, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    rd(1'b0, 8'd5, 32'hB000_0005, "t6_pre_reset_snapshot");
    step_to(t0 + 200);
    chk("t6_stays_idle", busy, 0);
    base = 32'hF000_0000;
    step();
    pulse_vsync();
    wait_idle("t6_rescan_len");
    chk("t6_rescan_cnt", frame_cnt, 1);
    rd(1'b0, 8'd5, 32'hF000_0005, "t6_rescan_rd5");
    rd(1'b0, 8'd127, 32'hF000_007F, "t6_rescan_rd127");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
